// File: rtl/ahb_scratch_slave.sv
// AHB-Lite scratch RAM slave with wait states, ERROR responses and a doorbell interrupt.
// Optional write-privilege check enabled by defining AHB_SCRATCH_PROT_EN.
module ahb_scratch_slave #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned DOORBELL_IDX = (1 << ADDR_W) - 1
) (
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic        intr
);

  localparam int unsigned        DEPTH     = 1 << ADDR_W;
  localparam logic [2:0]         WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
  localparam logic [ADDR_W-1:0]  DB_IDX    = ADDR_W'(DOORBELL_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic              wr_q, wr_d;
  logic [2:0]        size_q, size_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              intr_q, intr_d;
  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              bad;
  logic              prot_bad;
  logic [3:0]        be;
  logic              data_ph;
  logic              unused_bits;

  assign unused_bits = ^{haddr[31:ADDR_W+2], htrans[0], hprot};

  assign hready  = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign hresp   = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
  assign accept  = hsel & htrans[1] & hready;
  assign data_ph = (state_q == S_DATA);
  assign hrdata  = (data_ph && !wr_q) ? mem_q[idx_q] : '0;
  assign intr    = intr_q;

`ifdef AHB_SCRATCH_PROT_EN
  assign prot_bad = hwrite & ~hprot[1];
`else
  assign prot_bad = 1'b0;
`endif

  always_comb begin
    bad = prot_bad;
    case (hsize)
      3'd0:    bad = prot_bad;
      3'd1:    if (haddr[0]) bad = 1'b1;
      3'd2:    if (haddr[1:0] != 2'b00) bad = 1'b1;
      default: bad = 1'b1;
    endcase
  end

  // Accept is only possible when hready=1 (IDLE/DATA/ERR2), so it takes priority
  // over the per-state advance and gives back-to-back chaining for free.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wr_d    = wr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    if (accept) begin
      idx_d  = haddr[ADDR_W+1:2];
      lane_d = haddr[1:0];
      wr_d   = hwrite;
      size_d = hsize;
      cnt_d  = WAIT_LOAD;
      if (bad)                  state_d = S_ERR1;
      else if (WAIT_STATES > 0) state_d = S_WAIT;
      else                      state_d = S_DATA;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 3'd0) state_d = S_DATA;
          else               cnt_d   = cnt_q - 3'd1;
        end
        S_ERR1:  state_d = S_ERR2;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[lane_q] = 1'b1;
      3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    intr_d = intr_q;
    if (data_ph && idx_q == DB_IDX) intr_d = wr_q;
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
    end
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (data_ph && wr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_scratch_slave.sv
// Scoreboard bench for ahb_scratch_slave: zero-wait and 3-wait instances on a shared bus.
module tb_ahb_scratch_slave;

  logic        hclk = 1'b0;
  logic        hrst_b = 1'b0;
  logic        hsel0 = 1'b0, hsel1 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [3:0]  hprot = 4'b0011;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1;
  logic [1:0]  hresp0, hresp1;
  logic        intr0, intr1;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_scratch_slave #(.ADDR_W(4), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0), .hresp(hresp0), .intr(intr0)
  );

  ahb_scratch_slave #(.ADDR_W(4), .WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata1), .hready(hready1), .hresp(hresp1), .intr(intr1)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  prot;
    logic        err;
    logic [31:0] rdata;
  } xfer_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  xfer_t xq[$];
  exp_t  sb[$];

  task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input logic [3:0] prot,
                     input logic err, input logic [31:0] rdata);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    x.prot = prot; x.err = err; x.rdata = rdata;
    xq.push_back(x);
  endtask

  // Drives queued transfers pipelined onto the bus; starts and ends 1 time unit after a rising edge.
  task automatic run_bus(input bit tgt);
    exp_t  cur;
    exp_t  e;
    xfer_t x;
    bit    have = 0;
    int    waits = 0;
    int    guard = 0;
    int    exp_waits;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdat;
    while ((xq.size() > 0 || have) && guard < 200) begin
      if (xq.size() > 0) begin
        x = xq[0];
        hsel0 = !tgt; hsel1 = tgt; htrans = 2'b10;
        haddr = x.addr; hwrite = x.wr; hsize = x.size; hprot = x.prot;
      end else begin
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
        haddr = '0; hwrite = 1'b0; hsize = '0; hprot = 4'b0011;
      end
      hwdata = have ? cur.wdata : '0;
      @(negedge hclk);
      rdy  = tgt ? hready1 : hready0;
      resp = tgt ? hresp1  : hresp0;
      rdat = tgt ? hrdata1 : hrdata0;
      if (have) begin
        if (rdy) begin
          exp_waits = cur.err ? 1 : (tgt ? 3 : 0);
          checks++;
          if (resp !== (cur.err ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL hresp_final got %b exp %b", resp, cur.err ? 2'b01 : 2'b00);
          end
          checks++;
          if (waits != exp_waits) begin
            errors++; $display("FAIL wait_cycles got %0d exp %0d", waits, exp_waits);
          end
          checks++;
          if (rdat !== cur.rdata) begin
            errors++; $display("FAIL hrdata got %08h exp %08h", rdat, cur.rdata);
          end
          have = 0;
        end else begin
          waits++;
          checks++;
          if (resp !== (cur.err ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL hresp_stall got %b exp %b", resp, cur.err ? 2'b01 : 2'b00);
          end
        end
      end
      if (rdy && xq.size() > 0) begin
        x = xq.pop_front();
        e.err = x.err; e.rdata = x.rdata; e.wdata = x.wdata;
        sb.push_back(e);
      end
      @(posedge hclk); #1;
      if (!have && sb.size() > 0) begin
        cur = sb.pop_front(); have = 1; waits = 0;
      end
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL bus_timeout got %0d cycles exp <200", guard);
      xq.delete(); sb.delete();
    end
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0; hprot = 4'b0011;
  endtask

  task automatic test_reset();
    hrst_b = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checks++;
    if (hready0 !== 1'b1 || hresp0 !== 2'b00 || hrdata0 !== 32'h0 || intr0 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b resp=%b rd=%08h intr=%b exp 1 00 0 0",
                         hready0, hresp0, hrdata0, intr0);
    end
    @(posedge hclk); #1 hrst_b = 1'b1;
    @(negedge hclk);
    checks++;
    if (hready0 !== 1'b1 || hresp0 !== 2'b00 || intr0 !== 1'b0 || hready1 !== 1'b1) begin
      errors++; $display("FAIL post_reset got rdy=%b resp=%b intr=%b rdy1=%b exp 1 00 0 1",
                         hready0, hresp0, intr0, hready1);
    end
    @(posedge hclk); #1;
    add(0, 32'h0C, 3'd2, 0, 4'b0011, 0, 32'h0);
    run_bus(0);
  endtask

  task automatic test_word_rw();
    add(1, 32'h08, 3'd2, 32'hDEADBEEF, 4'b0011, 0, 32'h0);
    add(0, 32'h08, 3'd2, 0,            4'b0011, 0, 32'hDEADBEEF);
    run_bus(0);
  endtask

  task automatic test_lanes();
    add(1, 32'h0C, 3'd2, 32'h11223344, 4'b0011, 0, 32'h0);
    add(1, 32'h0E, 3'd0, 32'h00AA0000, 4'b0011, 0, 32'h0);
    add(1, 32'h0C, 3'd1, 32'h00005566, 4'b0011, 0, 32'h0);
    add(0, 32'h0C, 3'd2, 0,            4'b0011, 0, 32'h11AA5566);
    add(1, 32'h12, 3'd1, 32'hBEEF0000, 4'b0011, 0, 32'h0);
    add(1, 32'h11, 3'd0, 32'h00007700, 4'b0011, 0, 32'h0);
    add(0, 32'h10, 3'd2, 0,            4'b0011, 0, 32'hBEEF7700);
    run_bus(0);
  endtask

  task automatic test_errors();
    add(1, 32'h05, 3'd2, 32'hCAFEF00D, 4'b0011, 1, 32'h0);
    add(0, 32'h00, 3'd3, 0,            4'b0011, 1, 32'h0);
    add(1, 32'h05, 3'd1, 32'h12345678, 4'b0011, 1, 32'h0);
    add(0, 32'h04, 3'd2, 0,            4'b0011, 0, 32'h0);
    run_bus(0);
  endtask

  task automatic test_wait_states();
    add(0, 32'h08, 3'd2, 0,            4'b0011, 0, 32'h0);
    add(1, 32'h08, 3'd2, 32'h12345678, 4'b0011, 0, 32'h0);
    add(0, 32'h08, 3'd2, 0,            4'b0011, 0, 32'h12345678);
    run_bus(1);
  endtask

  task automatic test_doorbell();
    checks++;
    if (intr0 !== 1'b0) begin errors++; $display("FAIL intr_initial got %b exp 0", intr0); end
    add(1, 32'h3C, 3'd2, 32'h1, 4'b0011, 0, 32'h0);
    run_bus(0);
    checks++;
    if (intr0 !== 1'b1) begin errors++; $display("FAIL intr_set got %b exp 1", intr0); end
    add(1, 32'h20, 3'd2, 32'h5, 4'b0011, 0, 32'h0);
    run_bus(0);
    checks++;
    if (intr0 !== 1'b1) begin errors++; $display("FAIL intr_hold got %b exp 1", intr0); end
    add(0, 32'h3C, 3'd2, 0, 4'b0011, 0, 32'h1);
    run_bus(0);
    checks++;
    if (intr0 !== 1'b0) begin errors++; $display("FAIL intr_clear got %b exp 0", intr0); end
`ifdef AHB_SCRATCH_PROT_EN
    add(1, 32'h3C, 3'd2, 32'h2, 4'b0001, 1, 32'h0);
    add(0, 32'h3C, 3'd2, 0,     4'b0011, 0, 32'h1);
    run_bus(0);
    checks++;
    if (intr0 !== 1'b0) begin errors++; $display("FAIL intr_user_write got %b exp 0", intr0); end
`else
    add(1, 32'h3C, 3'd2, 32'h2, 4'b0001, 0, 32'h0);
    run_bus(0);
    checks++;
    if (intr0 !== 1'b1) begin errors++; $display("FAIL intr_prot_ignored got %b exp 1", intr0); end
`endif
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_wait_states();
    test_doorbell();
    repeat (2) @(posedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_scratch_slave.md
Name: ahb_scratch_slave

Overview:
- Parametrised successor to the fixed AHB stub slave: AHB-Lite slave with real storage, configurable wait states, ERROR responses and a doorbell interrupt.
- Provides a 2^ADDR_W-word scratch RAM built from flops, for bring-up, bus-matrix testing and simple CPU-to-host signalling.
- Sits behind the AHB decoder in the slot a stub slave would otherwise occupy.

Parameters:
- ADDR_W, 4: word-index bits; DEPTH = 2^ADDR_W words of 32 bits; legal range 2..8.
- WAIT_STATES, 0: hready-low cycles inserted before every OKAY data phase; legal range 0..7.
- DOORBELL_IDX, 2^ADDR_W-1: word index of the doorbell word.

Ports:
- hclk  in  1  bus clock; all state on rising edge.
- hrst_b  in  1  asynchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address; only [ADDR_W+1:0] decoded.
- htrans  in  2  transfer type; a transfer is NONSEQ or SEQ (htrans[1]=1).
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word.
- hprot  in  4  protection; used only with the optional feature.
- hwdata  in  32  write data, valid in the data phase.
- hrdata  out  32  read data.
- hready  out  1  transfer done / slave ready.
- hresp  out  2  00 = OKAY, 01 = ERROR.
- intr  out  1  doorbell interrupt, level.

Behaviour:
- Reset (hrst_b=0, asynchronous): hready=1, hresp=00, hrdata=0, intr=0, all storage words=0, FSM=IDLE.
- Accept: an address phase is accepted when hsel & htrans[1] & hready (own hready output). The block latches index=haddr[ADDR_W+1:2], lane=haddr[1:0], hwrite and hsize. IDLE/BUSY or hsel=0 are not accepted and give zero-wait OKAY.
- Error check at accept:
  - hsize>2 → error.
  - hsize=1 with lane[0]≠0 → error.
  - hsize=2 with lane≠0 → error.
- FSM:
  - IDLE: good accept → WAIT (if WAIT_STATES>0) else DATA; bad accept → ERR1.
  - WAIT: counts WAIT_STATES cycles with hready=0, hresp=00, then → DATA.
  - DATA: hready=1, hresp=00.
    - Write: storage is updated on this edge, using byte enables from hsize/lane (little-endian).
    - Read: hrdata = storage[index], read combinationally in this cycle.
    - A new accept in the same cycle chains directly into WAIT/DATA/ERR1; otherwise → IDLE.
  - ERR1: hready=0, hresp=01 → ERR2.
  - ERR2: hready=1, hresp=01. Writes are discarded. Next accept is evaluated as in DATA.
- Latency: WAIT_STATES=0 gives back-to-back single-cycle data phases. A read immediately after a write to the same word returns the new data.
- hrdata is 0 in every cycle except a read DATA cycle.
- Doorbell:
  - Any OKAY write to DOORBELL_IDX stores the data and sets intr=1.
  - An OKAY read of DOORBELL_IDX returns the stored data; intr clears on the same edge.
  - intr is unchanged by all other accesses.
- Reset mid-transfer aborts the transfer: no write commit, outputs return to reset values.

Optional Feature:
- Macro: AHB_SCRATCH_PROT_EN.
- Defined: an accepted write with hprot[1]=0 (user mode) is treated as an error (ERR1/ERR2), storage is not written, and intr is not set. Reads are unaffected.
- Undefined: hprot is ignored entirely.

Test Plan:
- Reset: after hrst_b release → hready=1, hresp=00, intr=0; a word read of index 3 → hrdata=0x00000000.
- Word write then read, WAIT_STATES=0: write 0xDEADBEEF @0x08 followed back-to-back by a read @0x08 → read DATA cycle hrdata=0xDEADBEEF, hready never low.
- Byte/halfword lanes:
  - Word write 0x11223344 @0x0C.
  - Byte write 0xAA @0x0E (hwdata=0x00AA0000).
  - Half write 0x5566 @0x0C.
  - → word read @0x0C = 0x11AA5566.
- Errors:
  - Word write @0x05 → cycle 1: hready=0, hresp=01; cycle 2: hready=1, hresp=01; storage unchanged.
  - hsize=3 read → same two-cycle ERROR.
- Wait states, WAIT_STATES=3: read → exactly 3 cycles hready=0, then 1 cycle hready=1, hresp=00.
- Doorbell, ADDR_W=4: write 0x1 @0x3C → intr=1 next cycle; read @0x3C → returns 0x1 and intr=0 after that edge. With AHB_SCRATCH_PROT_EN and hprot=4'b0001, the write gets ERROR and intr stays 0.
